// File: rtl/lcd_pkg.sv
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared arbitration constants and scheduler FSM encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_update_scheduler_chan_tracker.sv
// ============================================================================
// Module   : chan_tracker
// Brief    : Per-channel shadow register and pending flag (set beats clear).
// Revision : 1.0
// ============================================================================
`default_nettype none

module chan_tracker #(
  parameter int                WIDTH       = 3,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ch_i,
  input  logic             set_refresh,
  input  logic             clr_serve,
  output logic [WIDTH-1:0] value,
  output logic             pending
);

  logic [WIDTH-1:0] shadow_q;
  logic             pending_q;
  logic             pending_d;
  logic             changed;

  assign changed   = (ch_i != shadow_q);
  assign pending_d = (pending_q & ~clr_serve) | changed | set_refresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= RESET_VALUE;
      pending_q <= 1'b0;
    end else begin
      if (changed) begin
        shadow_q <= ch_i;
      end
      pending_q <= pending_d;
    end
  end

  assign value   = shadow_q;
  assign pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/lcd_update_scheduler.sv
// ============================================================================
// Module   : lcd_update_scheduler
// Brief    : Coalescing change detector that offers one channel update at a
//            time to the LCD writer, with optional hold-off between updates.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_update_scheduler
  import lcd_pkg::*;
#(
  parameter int                       NUM_CH       = 4,
  parameter int                       WIDTH        = 3,
  parameter logic [NUM_CH*WIDTH-1:0]  RESET_VALUES = '0,
  parameter int                       ARB_MODE     = ARB_FIXED,
  parameter int                       HOLDOFF      = 0,
  parameter int                       IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] ch_in,
  input  logic                    refresh_all,
  output logic                    upd_valid,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [WIDTH-1:0]        upd_data,
  input  logic                    upd_ready,
  output logic [NUM_CH-1:0]       pending,
  output logic                    busy
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] clr_vec;
  logic [WIDTH-1:0]  ch_arr   [NUM_CH];
  logic [WIDTH-1:0]  shad_arr [NUM_CH];
  logic [WIDTH-1:0]  post_arr [NUM_CH];

  logic              serve;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              hi_found, lo_found;
  logic [IDX_W-1:0]  hi_idx, lo_idx;
  int                base;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_arr[gi]  = ch_in[gi*WIDTH +: WIDTH];
    assign clr_vec[gi] = serve && (sel_idx == IDX_W'(gi));
    // Shadow value as it will be after this edge, so a served channel
    // that is changing right now is offered with its newest value.
    assign post_arr[gi] = (ch_arr[gi] != shad_arr[gi]) ? ch_arr[gi] : shad_arr[gi];

    chan_tracker #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUES[gi*WIDTH +: WIDTH])
    ) u_trk (
      .clk         (clk),
      .reset       (reset),
      .ch_i        (ch_arr[gi]),
      .set_refresh (refresh_all),
      .clr_serve   (clr_vec[gi]),
      .value       (shad_arr[gi]),
      .pending     (pend_vec[gi])
    );
  end

  // Lowest pending index at or above the search base, else lowest overall.
  always_comb begin
    base     = (ARB_MODE == ARB_RR) ? int'(ptr_q) : 0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (pend_vec[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
      end
      if (pend_vec[j] && !hi_found && (j >= base)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(j);
      end
    end
    sel_found = lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    serve   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          serve   = 1'b1;
          idx_d   = sel_idx;
          data_d  = post_arr[sel_idx];
          ptr_d   = (sel_idx == IDX_W'(NUM_CH - 1)) ? '0 : sel_idx + IDX_W'(1);
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (upd_ready) begin
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLDOFF - 1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign upd_valid = (state_q == OFFER);
  assign upd_idx   = idx_q;
  assign upd_data  = data_q;
  assign pending   = pend_vec;
  assign busy      = (state_q != IDLE) || (|pend_vec);

endmodule

`default_nettype wire

// File: doc/lcd_update_scheduler.md
# lcd_update_scheduler

Parametrised change detector and update scheduler for the LCD status path. Watches NUM_CH status channels (face plus statistics, or any future additions), remembers which ones changed, and hands them one at a time to the LCD writer over a valid/ready handshake. Rapid changes are coalesced, so the writer always receives the latest value. A hold-off gap between updates keeps the display from thrashing. Sits between the pet state logic and the LCD controller, replacing the single-bit new-update flag.

## Interface
- NUM_CH, 4: number of monitored channels (≥1)
- WIDTH, 3: bits per channel value
- RESET_VALUES, {NUM_CH*WIDTH{1'b0}}: packed per-channel reset values; channel i occupies bits [i*WIDTH +: WIDTH]
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin
- HOLDOFF, 0: idle cycles enforced after each accepted update (0 = none)
- IDX_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1): index width (derived, do not override)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_in  in  NUM_CH*WIDTH  packed channel values, sampled every cycle
- refresh_all  in  1  one-cycle pulse; marks every channel pending
- upd_valid  out  1  an update is offered
- upd_idx  out  IDX_W  channel index of the offered update
- upd_data  out  WIDTH  value of the offered update
- upd_ready  in  1  LCD writer accepts the offered update
- pending  out  NUM_CH  per-channel pending mask
- busy  out  1  high when the FSM state is not IDLE or any pending bit is set

## Operation
- Each channel has a shadow register and a pending bit.
- At each edge, if ch_in[i] ≠ shadow[i]: shadow[i] ← ch_in[i] and pending[i] ← 1.
- refresh_all sets all pending bits. It does not modify the shadows.
- FSM states are IDLE, OFFER and HOLD.
- IDLE with pending ≠ 0:
  - select channel s by ARB_MODE;
  - latch upd_idx ← s and upd_data ← shadow[s] (post-update value if s changes on this edge);
  - clear pending[s];
  - go to OFFER.
- IDLE with pending = 0: stay in IDLE.
- OFFER: upd_valid = 1. upd_idx and upd_data stay stable until upd_valid && upd_ready.
- On that handshake: go to HOLD with counter ← HOLDOFF−1, or go to IDLE when HOLDOFF = 0.
- HOLD: decrement the counter. When it reaches 0, go to IDLE.
- Coalescing: a channel that changes while pending stays pending once and gets its newest value when served.
- A channel that changes while in OFFER (including the one being offered) becomes pending again. The offered data does not change.
- Round-robin: after serving s, the search starts at s+1 modulo NUM_CH. The pointer resets to 0.
- Fixed priority: the lowest set pending index wins.

## Timing
- Reset values:
  - shadows = RESET_VALUES;
  - pending = 0;
  - state = IDLE;
  - upd_valid = 0, upd_idx = 0, upd_data = 0;
  - busy = 0;
  - round-robin pointer = 0;
  - hold-off counter = 0.
- Input change before edge k → pending bit visible after edge k → upd_valid high after edge k+1. Minimum latency is 2 cycles.
- Handshake at edge h with HOLDOFF = H > 0:
  - next selection at edge h+H+1;
  - upd_valid high again after edge h+H+1.
- HOLDOFF = 0 and further pending: upd_valid goes low for exactly one cycle (the IDLE cycle), then reasserts.
- upd_ready while upd_valid = 0 is ignored.
- Clear/set on the same edge for the same channel (served in IDLE while changing or refreshed): set wins and the pending bit stays 1.
- Reset mid-OFFER or mid-HOLD:
  - the update is dropped and all pending bits are cleared;
  - shadows are restored to RESET_VALUES;
  - any ch_in differing from RESET_VALUES after reset release becomes pending on the first edge.
- Channel index arithmetic wraps modulo NUM_CH. With NUM_CH = 1, upd_idx is always 0.

## Structure
- Shared package lcd_pkg holds:
  - the ARB_FIXED = 0 and ARB_RR = 1 constants;
  - the FSM state encoding (IDLE, OFFER, HOLD).
- One sub-module, chan_tracker (WIDTH, RESET_VALUE), is instantiated NUM_CH times. It holds the shadow and pending bit, with inputs set_refresh and clr_serve, and outputs value and pending.
- Arbiter, FSM and hold-off counter live in the top level.

## Test plan
- Reset release with ch_in = RESET_VALUES → pending = 0, upd_valid = 0 for 20 cycles, busy = 0.
- NUM_CH = 4, WIDTH = 3, ARB_MODE = 0, upd_ready tied 1: change ch2 to 3 and ch0 to 5 on the same edge → ch0 is served first (upd_idx = 0, upd_data = 5), then ch2 (upd_idx = 2, upd_data = 3). upd_valid first rises 2 cycles after the change.
- ARB_MODE = 1, all channels pending via refresh_all → served in order 0, 1, 2, 3. A re-pended ch0 is served after ch3.
- upd_ready held 0 while ch1 goes 1 → 2 → 4 during OFFER of ch1 = 1:
  - upd_data stays 1 until accept;
  - ch1 is then served once with value 4.
- HOLDOFF = 5, two channels pending → after the first accept at edge h, upd_valid rises again after edge h+6. busy stays 1 throughout.
- Assert reset during OFFER → upd_valid drops immediately. After release, only channels whose ch_in differs from RESET_VALUES are served.
